// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: three-requester round-robin arbiter in front of one
// registered output channel. Multi-beat bursts (closed by *_last) are kept
// atomic by locking the grant to the burst owner. The select code tells an
// external three-input mux which source the registered beat came from.
module mux3_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    input  logic             c_valid,
    input  logic [WIDTH-1:0] c_data,
    input  logic             c_last,
    output logic             c_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       select
);

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    // Output register and arbitration state.
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;
    logic [1:0]       select_r;
    logic [1:0]       ptr_r;      // last requester accepted
    logic             lock_r;     // a burst is in progress
    logic [1:0]       owner_r;    // owner of the burst in progress

    logic [2:0]       vld_s;      // indexed by select code
    logic [2:0]       pick_s;     // {found, code}
    logic             load_en_s;
    logic             gnt_vld_s;
    logic [1:0]       gnt_s;
    logic [WIDTH-1:0] gnt_data_s;
    logic             gnt_last_s;

    // Returns {found, code} for the first valid requester in the given order.
    function automatic logic [2:0] rr_pick(
        input logic [1:0] first,
        input logic [1:0] second,
        input logic [1:0] third,
        input logic [2:0] vld
    );
        logic [2:0] res;
        if (vld[first]) begin
            res = {1'b1, first};
        end else if (vld[second]) begin
            res = {1'b1, second};
        end else if (vld[third]) begin
            res = {1'b1, third};
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    assign vld_s     = {c_valid, b_valid, a_valid};
    assign load_en_s = !out_valid_r | out_ready;
    assign gnt_vld_s = pick_s[2];
    assign gnt_s     = pick_s[1:0];

    // Grant selection: locked owner only during a burst, else round-robin after ptr_r.
    always_comb begin
        pick_s = 3'b000;
        if (lock_r) begin
            if (vld_s[owner_r]) begin
                pick_s = {1'b1, owner_r};
            end else begin
                pick_s = 3'b000;
            end
        end else begin
            case (ptr_r)
                SEL_A:   pick_s = rr_pick(SEL_B, SEL_C, SEL_A, vld_s);
                SEL_B:   pick_s = rr_pick(SEL_C, SEL_A, SEL_B, vld_s);
                default: pick_s = rr_pick(SEL_A, SEL_B, SEL_C, vld_s);
            endcase
        end
    end

    // Steer the granted requester's beat toward the output register.
    always_comb begin
        gnt_data_s = {WIDTH{1'b0}};
        gnt_last_s = 1'b0;
        case (gnt_s)
            SEL_A: begin
                gnt_data_s = a_data;
                gnt_last_s = a_last;
            end
            SEL_B: begin
                gnt_data_s = b_data;
                gnt_last_s = b_last;
            end
            default: begin
                gnt_data_s = c_data;
                gnt_last_s = c_last;
            end
        endcase
    end

    // A grant is only ever issued to a valid requester, so ready never rises without valid.
    assign a_ready = load_en_s & gnt_vld_s & (gnt_s == SEL_A);
    assign b_ready = load_en_s & gnt_vld_s & (gnt_s == SEL_B);
    assign c_ready = load_en_s & gnt_vld_s & (gnt_s == SEL_C);

    // Output register, round-robin pointer and burst lock; all move only when the register can load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            select_r    <= SEL_A;
            ptr_r       <= SEL_C;
            lock_r      <= 1'b0;
            owner_r     <= SEL_A;
        end else if (load_en_s) begin
            if (gnt_vld_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= gnt_data_s;
                out_last_r  <= gnt_last_s;
                select_r    <= gnt_s;
                ptr_r       <= gnt_s;
                lock_r      <= !gnt_last_s;
                owner_r     <= gnt_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign select    = select_r;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Testbench for mux3_rr_arbiter: per-requester beat queues drive the inputs,
// expected output beats go into a scoreboard queue and are compared as the
// sink takes each beat.
module tb_mux3_rr_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [3:0] gap;    // idle cycles before this beat is offered
    } beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] vld;
    logic [2:0] lst;
    logic [7:0] dat [3];
    logic       a_ready, b_ready, c_ready;
    logic       out_valid, out_last, out_rdy;
    logic [7:0] out_data;
    logic [1:0] select;

    beat_t rq [3][$];
    exp_t  exp_q [$];
    int    n_checks = 0;
    int    n_errors = 0;

    mux3_rr_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (vld[0]),
        .a_data    (dat[0]),
        .a_last    (lst[0]),
        .a_ready   (a_ready),
        .b_valid   (vld[1]),
        .b_data    (dat[1]),
        .b_last    (lst[1]),
        .b_ready   (b_ready),
        .c_valid   (vld[2]),
        .c_data    (dat[2]),
        .c_last    (lst[2]),
        .c_ready   (c_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_rdy),
        .select    (select)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Safety net in case some wait never completes.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_beat(input int r, input logic [7:0] d, input logic l, input logic [3:0] g);
        beat_t b;
        b.data = d;
        b.last = l;
        b.gap  = g;
        rq[r].push_back(b);
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.last = l;
        e.sel  = s;
        exp_q.push_back(e);
    endtask

    // Retire accepted beats and present each requester's next beat (honouring gaps).
    task automatic present(input logic [2:0] acc);
        beat_t h;
        for (int i = 0; i < 3; i++) begin
            if (acc[i] && rq[i].size() > 0) begin
                void'(rq[i].pop_front());
            end
            if (rq[i].size() == 0) begin
                vld[i] = 1'b0;
            end else if (rq[i][0].gap != 4'd0) begin
                vld[i] = 1'b0;
                h = rq[i][0];
                h.gap = h.gap - 4'd1;
                rq[i][0] = h;
            end else begin
                vld[i] = 1'b1;
                dat[i] = rq[i][0].data;
                lst[i] = rq[i][0].last;
            end
        end
    endtask

    // One clock: sample handshakes and score the output beat, then advance the requesters.
    task automatic cycle();
        logic [2:0] acc;
        exp_t       e;
        #1;
        acc = vld & {c_ready, b_ready, a_ready};
        if (out_valid && out_rdy) begin
            check_val("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("out_data", 32'(out_data), 32'(e.data));
                check_val("out_last", 32'(out_last), 32'(e.last));
                check_val("select", 32'(select), 32'(e.sel));
            end
        end
        @(posedge clk);
        #1;
        present(acc);
        @(negedge clk);
    endtask

    task automatic drain(output int n);
        n = 0;
        while ((exp_q.size() > 0 || rq[0].size() > 0 || rq[1].size() > 0 || rq[2].size() > 0)
               && n < 60) begin
            cycle();
            n++;
        end
        check_val("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) begin
            rq[i].delete();
        end
        exp_q.delete();
        vld = 3'b000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        out_rdy = 1'b1;
        vld     = 3'b000;
        lst     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            dat[i] = 8'h00;
        end
        do_reset();

        // 1: reset state, idle
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_select", 32'(select), 32'd0);
        check_val("rst_readies", 32'({c_ready, b_ready, a_ready}), 32'd0);
        check_val("rst_out_data", 32'(out_data), 32'd0);
        check_val("rst_out_last", 32'(out_last), 32'd0);
        repeat (10) cycle();
        check_val("idle_out_valid", 32'(out_valid), 32'd0);
        check_val("idle_select", 32'(select), 32'd0);
        check_val("idle_readies", 32'({c_ready, b_ready, a_ready}), 32'd0);

        // 2: round-robin over single-beat requests, one beat per cycle
        push_beat(0, 8'h11, 1'b1, 4'd0);
        push_beat(0, 8'h11, 1'b1, 4'd0);
        push_beat(1, 8'h22, 1'b1, 4'd0);
        push_beat(2, 8'h33, 1'b1, 4'd0);
        expect_beat(8'h11, 1'b1, 2'b00);
        expect_beat(8'h22, 1'b1, 2'b01);
        expect_beat(8'h33, 1'b1, 2'b10);
        expect_beat(8'h11, 1'b1, 2'b00);
        present(3'b000);
        drain(n);
        check_val("rr_cycles", 32'(n), 32'd5);

        // 3: b's 3-beat burst stays contiguous, then c
        push_beat(1, 8'hB1, 1'b0, 4'd0);
        push_beat(1, 8'hB2, 1'b0, 4'd0);
        push_beat(1, 8'hB3, 1'b1, 4'd0);
        push_beat(0, 8'hA1, 1'b1, 4'd0);
        push_beat(2, 8'hC1, 1'b1, 4'd0);
        expect_beat(8'hB1, 1'b0, 2'b01);
        expect_beat(8'hB2, 1'b0, 2'b01);
        expect_beat(8'hB3, 1'b1, 2'b01);
        expect_beat(8'hC1, 1'b1, 2'b10);
        expect_beat(8'hA1, 1'b1, 2'b00);
        present(3'b000);
        drain(n);

        // 4: stall with c's 0x5A held, then release
        out_rdy = 1'b0;
        push_beat(2, 8'h5A, 1'b1, 4'd0);
        push_beat(0, 8'h77, 1'b1, 4'd0);
        expect_beat(8'h5A, 1'b1, 2'b10);
        expect_beat(8'h77, 1'b1, 2'b00);
        present(3'b000);
        cycle();
        for (int k = 0; k < 5; k++) begin
            check_val("stall_valid", 32'(out_valid), 32'd1);
            check_val("stall_data", 32'(out_data), 32'h5A);
            check_val("stall_select", 32'(select), 32'd2);
            check_val("stall_readies", 32'({c_ready, b_ready, a_ready}), 32'd0);
            cycle();
        end
        out_rdy = 1'b1;
        cycle();
        check_val("unstall_valid", 32'(out_valid), 32'd1);
        check_val("unstall_data", 32'(out_data), 32'h77);
        check_val("unstall_select", 32'(select), 32'd0);
        drain(n);

        // 5: a locked mid-burst, a_valid gap while b waits
        push_beat(0, 8'hA1, 1'b0, 4'd0);
        push_beat(0, 8'hA2, 1'b1, 4'd2);
        push_beat(1, 8'hB1, 1'b1, 4'd1);
        expect_beat(8'hA1, 1'b0, 2'b00);
        expect_beat(8'hA2, 1'b1, 2'b00);
        expect_beat(8'hB1, 1'b1, 2'b01);
        present(3'b000);
        cycle();
        check_val("gap1_b_ready", 32'(b_ready), 32'd0);
        cycle();
        check_val("gap2_b_ready", 32'(b_ready), 32'd0);
        check_val("gap2_out_valid", 32'(out_valid), 32'd0);
        cycle();
        check_val("resume_a_ready", 32'(a_ready), 32'd1);
        check_val("resume_b_ready", 32'(b_ready), 32'd0);
        drain(n);

        // 6: asynchronous reset mid-burst
        push_beat(0, 8'hD1, 1'b0, 4'd0);
        push_beat(0, 8'hD2, 1'b0, 4'd0);
        push_beat(0, 8'hD3, 1'b1, 4'd0);
        expect_beat(8'hD1, 1'b0, 2'b00);
        present(3'b000);
        cycle();
        cycle();
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'd0);
        check_val("async_rst_select", 32'(select), 32'd0);
        clear_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // lock must be gone: b proceeds while a is still idle
        push_beat(1, 8'hE1, 1'b1, 4'd0);
        push_beat(0, 8'hE2, 1'b1, 4'd2);
        expect_beat(8'hE1, 1'b1, 2'b01);
        expect_beat(8'hE2, 1'b1, 2'b00);
        present(3'b000);
        drain(n);
        // fresh reset: a has top priority
        do_reset();
        push_beat(2, 8'hF3, 1'b1, 4'd0);
        push_beat(1, 8'hF2, 1'b1, 4'd0);
        push_beat(0, 8'hF1, 1'b1, 4'd0);
        expect_beat(8'hF1, 1'b1, 2'b00);
        expect_beat(8'hF2, 1'b1, 2'b01);
        expect_beat(8'hF3, 1'b1, 2'b10);
        present(3'b000);
        drain(n);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
